// File: rtl/cube_move_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cube_move_engine
//  Description : Registered 54-sticker cube state with a small FSM that applies
//                a requested face turn as 1, 2 or 3 single-cycle clockwise
//                quarter turns. Emits busy/done/error and exports the state.
//                Optional macro CUBE_SOLVED_DETECT_EN adds a registered
//                "all faces uniform" flag; when undefined, solved is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cube_move_engine #(
    parameter bit TURN_CW_ONLY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   faceInput,
    input  logic [1:0]   rotationControl,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [161:0] cube_state,
    output logic         solved
);

    // Sticker k lives in element k, i.e. bits [3k+2:3k] once flattened.
    typedef logic [53:0][2:0] cube_t;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_turn = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Own-face clockwise rotation: new sticker i takes old sticker c_cw_src[i].
    localparam int c_cw_src [9] = '{6, 3, 0, 7, 4, 1, 8, 5, 2};

    // Home colour of every sticker is the index of the face it sits on.
    function automatic cube_t solved_cube();
        cube_t s;
        for (int k = 0; k < 54; k++) begin
            s[k] = 3'(k / 9);
        end
        return s;
    endfunction

    localparam cube_t c_solved_cube = solved_cube();

    // One-hot face select to face index (U0 R1 F2 D3 L4 B5).
    function automatic logic [2:0] face_index(input logic [5:0] onehot);
        logic [2:0] idx;
        case (onehot)
            6'b000001: idx = 3'd0;
            6'b000010: idx = 3'd1;
            6'b000100: idx = 3'd2;
            6'b001000: idx = 3'd3;
            6'b010000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Number of clockwise quarter turns realising the requested rotation.
    function automatic logic [1:0] turn_count(input logic [1:0] rot);
        logic [1:0] n;
        case (rot)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd3;
            2'd2:    n = 2'd2;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    // One clockwise quarter turn of the given face. Face base offsets:
    // U 0, R 9, F 18, D 27, L 36, B 45. Each ring assignment reads
    // "destination sticker <- source sticker" from the pre-turn state.
    function automatic cube_t quarter_turn(input cube_t cur, input logic [2:0] face);
        cube_t nxt;
        int    base;
        nxt  = cur;
        base = 9 * int'(face);
        if (face <= 3'd5) begin
            for (int i = 0; i < 9; i++) begin
                nxt[base + i] = cur[base + c_cw_src[i]];
            end
        end
        case (face)
            // U: top rows cycle F <- R <- B <- L <- F
            3'd0: for (int j = 0; j < 3; j++) begin
                nxt[18 + j] = cur[9 + j];
                nxt[9 + j]  = cur[45 + j];
                nxt[45 + j] = cur[36 + j];
                nxt[36 + j] = cur[18 + j];
            end
            // R: right column of U goes to B (reversed), B to D, D to F, F to U
            3'd1: for (int j = 0; j < 3; j++) begin
                nxt[51 - 3 * j] = cur[2 + 3 * j];
                nxt[35 - 3 * j] = cur[45 + 3 * j];
                nxt[20 + 3 * j] = cur[29 + 3 * j];
                nxt[2 + 3 * j]  = cur[20 + 3 * j];
            end
            // F: bottom row of U -> left column of R -> top row of D -> right column of L
            3'd2: for (int j = 0; j < 3; j++) begin
                nxt[9 + 3 * j]  = cur[6 + j];
                nxt[29 - j]     = cur[9 + 3 * j];
                nxt[38 + 3 * j] = cur[27 + j];
                nxt[8 - j]      = cur[38 + 3 * j];
            end
            // D: bottom rows cycle R <- F <- L <- B <- R
            3'd3: for (int j = 0; j < 3; j++) begin
                nxt[15 + j] = cur[24 + j];
                nxt[51 + j] = cur[15 + j];
                nxt[42 + j] = cur[51 + j];
                nxt[24 + j] = cur[42 + j];
            end
            // L: left column of U goes to F, F to D, D to B (reversed), B to U
            3'd4: for (int j = 0; j < 3; j++) begin
                nxt[18 + 3 * j] = cur[3 * j];
                nxt[27 + 3 * j] = cur[18 + 3 * j];
                nxt[53 - 3 * j] = cur[27 + 3 * j];
                nxt[6 - 3 * j]  = cur[47 + 3 * j];
            end
            // B: top row of U -> left column of L -> bottom row of D -> right column of R
            3'd5: for (int j = 0; j < 3; j++) begin
                nxt[42 - 3 * j] = cur[j];
                nxt[33 + j]     = cur[36 + 3 * j];
                nxt[17 - 3 * j] = cur[33 + j];
                nxt[j]          = cur[11 + 3 * j];
            end
            default: ;
        endcase
        return nxt;
    endfunction

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] r_count;
    logic [2:0] r_face;
    logic       r_error;
    cube_t      r_cube;
    cube_t      w_cube_next;
    logic       w_legal;
    logic       w_accept;
    logic       w_reject;

    // Command legality: exactly one face and a supported rotation code.
    always_comb begin
        w_legal  = $onehot(faceInput) && (rotationControl != 2'd3) &&
                   (!TURN_CW_ONLY || (rotationControl == 2'd0));
        w_accept = (r_state == c_st_idle) && start && w_legal;
        w_reject = (r_state == c_st_idle) && start && !w_legal;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; the last quarter turn is the one seen with count 1.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next_state = c_st_turn;
            c_st_turn: if (r_count <= 2'd1) w_next_state = c_st_done;
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // FSM outputs: busy and done are pure state decodes, error is the registered reject.
    always_comb begin
        busy       = (r_state == c_st_turn);
        done       = (r_state == c_st_done);
        error      = r_error;
        cube_state = r_cube;
`ifdef CUBE_SOLVED_DETECT_EN
        solved     = r_solved;
`else
        solved     = 1'b0;
`endif
    end

    // Command capture on the accepting edge; counter counts down remaining quarter turns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_face  <= 3'd0;
        end else if (w_accept) begin
            r_count <= turn_count(rotationControl);
            r_face  <= face_index(faceInput);
        end else if (r_state == c_st_turn) begin
            r_count <= r_count - 2'd1;
        end
    end

    // Illegal command pulse, visible the cycle after the rejecting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_reject;
        end
    end

    // Next cube state: one quarter turn per TURN cycle, otherwise hold.
    always_comb begin
        w_cube_next = r_cube;
        if (r_state == c_st_turn) begin
            w_cube_next = quarter_turn(r_cube, r_face);
        end
    end

    // Cube state register; reset restores the home colours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cube <= c_solved_cube;
        end else begin
            r_cube <= w_cube_next;
        end
    end

`ifdef CUBE_SOLVED_DETECT_EN
    logic r_solved;

    // Centres never move, so "every face uniform" equals "every sticker home".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_solved <= 1'b1;
        end else begin
            r_solved <= (w_cube_next == c_solved_cube);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cube_move_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cube_move_engine
//  Description : Self-checking bench for cube_move_engine. Reference model
//                derives every face turn from 3-D sticker geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_move_engine;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   faceInput;
    logic [1:0]   rotationControl;
    logic         busy;
    logic         done;
    logic         error;
    logic [161:0] cube_state;
    logic         solved;

    int n_tests = 0;
    int n_fail  = 0;

    int model [54];
    int dest_tbl [6][54];

    cube_move_engine #(.TURN_CW_ONLY(1'b0)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .faceInput       (faceInput),
        .rotationControl (rotationControl),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .cube_state      (cube_state),
        .solved          (solved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cubie position and outward normal of sticker k (x to R, y to U, z to F).
    function automatic void geom(input int k, output int px, output int py, output int pz,
                                 output int nx, output int ny, output int nz);
        int f, r, c;
        f = k / 9; r = (k % 9) / 3; c = k % 3;
        px = 0; py = 0; pz = 0; nx = 0; ny = 0; nz = 0;
        case (f)
            0: begin px = c - 1; py = 1;     pz = r - 1; ny = 1;  end
            1: begin px = 1;     py = 1 - r; pz = 1 - c; nx = 1;  end
            2: begin px = c - 1; py = 1 - r; pz = 1;     nz = 1;  end
            3: begin px = c - 1; py = -1;    pz = 1 - r; ny = -1; end
            4: begin px = -1;    py = 1 - r; pz = c - 1; nx = -1; end
            default: begin px = 1 - c; py = 1 - r; pz = -1; nz = -1; end
        endcase
    endfunction

    function automatic int locate(input int px, input int py, input int pz,
                                  input int nx, input int ny, input int nz);
        int qx, qy, qz, mx, my, mz;
        for (int k = 0; k < 54; k++) begin
            geom(k, qx, qy, qz, mx, my, mz);
            if (qx == px && qy == py && qz == pz && mx == nx && my == ny && mz == nz)
                return k;
        end
        return -1;
    endfunction

    // Rotate v by -90 degrees about unit axis a (clockwise seen from outside along a).
    function automatic void rot_cw(input int ax, input int ay, input int az,
                                   inout int vx, inout int vy, inout int vz);
        int cx, cy, cz, d;
        cx = ay * vz - az * vy;
        cy = az * vx - ax * vz;
        cz = ax * vy - ay * vx;
        d  = ax * vx + ay * vy + az * vz;
        vx = -cx + ax * d;
        vy = -cy + ay * d;
        vz = -cz + az * d;
    endfunction

    function automatic void build_perms();
        int ax, ay, az, px, py, pz, nx, ny, nz, t0, t1, t2;
        for (int f = 0; f < 6; f++) begin
            geom(9 * f + 4, t0, t1, t2, ax, ay, az);
            for (int k = 0; k < 54; k++) begin
                geom(k, px, py, pz, nx, ny, nz);
                if (px * ax + py * ay + pz * az == 1) begin
                    rot_cw(ax, ay, az, px, py, pz);
                    rot_cw(ax, ay, az, nx, ny, nz);
                    dest_tbl[f][k] = locate(px, py, pz, nx, ny, nz);
                end else begin
                    dest_tbl[f][k] = k;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 54; k++) model[k] = k / 9;
    endfunction

    function automatic void model_quarter(input int f);
        int tmp [54];
        for (int k = 0; k < 54; k++) tmp[dest_tbl[f][k]] = model[k];
        model = tmp;
    endfunction

    function automatic logic [161:0] model_packed();
        logic [161:0] v;
        v = '0;
        for (int k = 0; k < 54; k++) v[3 * k +: 3] = 3'(model[k]);
        return v;
    endfunction

    function automatic logic [161:0] home_packed();
        logic [161:0] v;
        v = '0;
        for (int k = 0; k < 54; k++) v[3 * k +: 3] = 3'(k / 9);
        return v;
    endfunction

    function automatic logic exp_solved();
`ifdef CUBE_SOLVED_DETECT_EN
        for (int k = 0; k < 54; k++) if (model[k] != k / 9) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [161:0] obs, input logic [161:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command as a one-cycle start strobe and check every following cycle.
    task automatic run_cmd(input logic [5:0] fsel, input logic [1:0] rsel, input string tag);
        int n, fi;
        bit legal;
        legal = ($countones(fsel) == 1) && (rsel != 2'd3);
        n  = (rsel == 2'd0) ? 1 : (rsel == 2'd1) ? 3 : 2;
        fi = 0;
        for (int b = 0; b < 6; b++) if (fsel[b]) fi = b;
        @(negedge clk);
        faceInput = fsel; rotationControl = rsel; start = 1'b1;
        if (legal) begin
            for (int p = 1; p <= n + 1; p++) begin
                @(negedge clk);
                if (p == 1) begin
                    start = 1'b0;
                    faceInput = 6'($urandom);
                    rotationControl = 2'($urandom);
                end
                if (p >= 2) model_quarter(fi);
                chk({tag, " busy"},   162'(busy),  162'(p <= n));
                chk({tag, " done"},   162'(done),  162'(p == n + 1));
                chk({tag, " error"},  162'(error), 162'(0));
                chk({tag, " cube"},   cube_state,  model_packed());
                chk({tag, " solved"}, 162'(solved), 162'(exp_solved()));
            end
            @(negedge clk);
            chk({tag, " idle busy"}, 162'(busy), 162'(0));
            chk({tag, " idle done"}, 162'(done), 162'(0));
        end else begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, " err pulse"}, 162'(error), 162'(1));
            chk({tag, " err busy"},  162'(busy),  162'(0));
            chk({tag, " err cube"},  cube_state,  model_packed());
            @(negedge clk);
            chk({tag, " err clear"}, 162'(error), 162'(0));
            chk({tag, " err nobusy"}, 162'(busy), 162'(0));
        end
    endtask

    initial begin
        int ndone;
        logic [5:0] fs;
        logic [1:0] rs;

        build_perms();
        model_reset();
        rst = 1'b1; start = 1'b0; faceInput = 6'd0; rotationControl = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst cube",   cube_state, home_packed());
        chk("rst busy",   162'(busy), 162'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle cube",   cube_state, home_packed());
        chk("idle busy",   162'(busy), 162'(0));
        chk("idle done",   162'(done), 162'(0));
        chk("idle error",  162'(error), 162'(0));
        chk("idle solved", 162'(solved), 162'(exp_solved()));

        // U cw from solved: known sticker colours on F and R top rows
        run_cmd(6'b000001, 2'd0, "U cw");
        chk("U cw F row0", 162'(cube_state[54 +: 9]), 162'({3'd1, 3'd1, 3'd1}));
        chk("U cw R row0", 162'(cube_state[27 +: 9]), 162'({3'd5, 3'd5, 3'd5}));
        chk("U cw U face", 162'(cube_state[0 +: 27]), 162'(27'd0));

        // U ccw undoes it
        run_cmd(6'b000001, 2'd1, "U ccw");
        chk("U ccw home", cube_state, home_packed());

        // U cw four times is identity
        for (int i = 0; i < 4; i++) run_cmd(6'b000001, 2'd0, "U cw x4");
        chk("U x4 home", cube_state, home_packed());

        // Illegal commands
        run_cmd(6'b000110, 2'd0, "two faces");
        run_cmd(6'b000100, 2'd3, "rot3");
        run_cmd(6'b000000, 2'd0, "no face");

        // Reset in the middle of an F double turn
        @(negedge clk);
        faceInput = 6'b000100; rotationControl = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst cube",  cube_state, home_packed());
        chk("midrst busy",  162'(busy), 162'(0));
        chk("midrst done",  162'(done), 162'(0));
        chk("midrst solved", 162'(solved), 162'(exp_solved()));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst no done", 162'(done), 162'(0));
            chk("midrst hold",    cube_state, home_packed());
        end

        // start held high with R cw: done every 3 cycles, identity after 4
        @(negedge clk);
        faceInput = 6'b000010; rotationControl = 2'd0; start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 20 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                model_quarter(1);
                chk("held spacing", 162'(cyc), 162'(2 + 3 * (ndone - 1)));
                chk("held cube",    cube_state, model_packed());
                if (ndone == 4) start = 1'b0;
            end
        end
        chk("held count", 162'(ndone), 162'(4));
        chk("held home",  cube_state, home_packed());
        chk("held solved", 162'(solved), 162'(exp_solved()));

        // Randomized commands against the geometric model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 8) fs = 6'(1 << $urandom_range(0, 5));
            else                          fs = 6'($urandom);
            rs = 2'($urandom_range(0, 3));
            run_cmd(fs, rs, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
